dbus_sel: RTL

DBUS_SEL -- requirements
Module: dbus_sel

---
 rtl/dbus_sel_pkg.sv | 24 ++
 rtl/dbus_sel_perf.sv | 31 +++
 rtl/dbus_sel.sv | 117 +++++++++++
 3 files changed

// File: rtl/dbus_sel_pkg.sv
// Shared types for the data-bus selector: request/response bundles
// and the selector FSM state encoding.
package dbus_sel_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [31:0] addr;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sel_state_e;

endpackage

// File: rtl/dbus_sel_perf.sv
// Wrapping 32-bit event counter for one dbus_sel path.
// Ports: clk, reset (async, active-high), inc (count enable), cnt (value).
// Only built when DBUS_SEL_PERF_EN is defined.
`ifdef DBUS_SEL_PERF_EN
module dbus_sel_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Natural 32-bit overflow gives the wrap to zero.
    always_comb begin
        cnt_d = cnt_q + (inc ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`endif

// File: rtl/dbus_sel.sv
// Routes one data-bus request at a time to the cache or uncached port.
// Ports: clk, reset, dreq/uncached in, dresp out, c_dreq/c_dresp and
// u_dreq/u_dresp downstream; perf_c_cnt/perf_u_cnt with DBUS_SEL_PERF_EN.
module dbus_sel
    import dbus_sel_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    input  logic       uncached,
    output dbus_resp_t dresp,
    output dbus_req_t  c_dreq,
    input  dbus_resp_t c_dresp,
    output dbus_req_t  u_dreq,
    input  dbus_resp_t u_dresp
`ifdef DBUS_SEL_PERF_EN
    ,
    output logic [31:0] perf_c_cnt,
    output logic [31:0] perf_u_cnt
`endif
);

    sel_state_e state_q;
    sel_state_e state_d;
    logic       sel_q;
    logic       sel_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        c_dreq       = dreq;
        c_dreq.valid = 1'b0;
        u_dreq       = dreq;
        u_dreq.valid = 1'b0;
        dresp        = '0;

        unique case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    if (uncached) begin
                        u_dreq.valid = 1'b1;
                        dresp        = u_dresp;
                    end else begin
                        c_dreq.valid = 1'b1;
                        dresp        = c_dresp;
                    end
                    // Accepted but not yet answered: park until data_ok.
                    if (dresp.addr_ok && !dresp.data_ok) begin
                        state_d = WAIT;
                        sel_d   = uncached;
                    end
                end
            end
            WAIT: begin
                // Only the path holding the transaction may complete it.
                if (sel_q) begin
                    dresp.data_ok = u_dresp.data_ok;
                    dresp.data    = u_dresp.data;
                end else begin
                    dresp.data_ok = c_dresp.data_ok;
                    dresp.data    = c_dresp.data;
                end
                if (dresp.data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshakes stay quiet for the whole reset pulse.
        if (reset) begin
            c_dreq.valid  = 1'b0;
            u_dreq.valid  = 1'b0;
            dresp.addr_ok = 1'b0;
            dresp.data_ok = 1'b0;
        end
    end

`ifdef DBUS_SEL_PERF_EN
    logic path_u;
    logic inc_c;
    logic inc_u;

    always_comb begin
        path_u = (state_q == IDLE) ? uncached : sel_q;
        inc_c  = dresp.data_ok && !path_u;
        inc_u  = dresp.data_ok && path_u;
    end

    dbus_sel_perf u_perf_c (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_c),
        .cnt   (perf_c_cnt)
    );

    dbus_sel_perf u_perf_u (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_u),
        .cnt   (perf_u_cnt)
    );
`endif

endmodule
